// File: rtl/uart_rx_if.sv
// Receive-side signal bundle between the serial pin, the receiver and its consumer.
// The master drives the line and the acknowledge; the slave is the receiver itself.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err,
        input  ovr
    );

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err,
        output ovr
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, sticky ready/error flags.
// Returns to IDLE at mid stop bit so zero-gap back-to-back frames are received.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 12'hA2C
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam logic [11:0] HALF_DIV = 12'(BAUD_DIV >> 1);
    localparam logic [11:0] BIT_DIV  = 12'(BAUD_DIV - 1);

    typedef enum logic {IDLE, RECEIVE} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  sreg_q, sreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        ovr_q, ovr_d;
    logic        pend_q, pend_d;
    logic        shift;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= bus.RX;
            rx_s_q     <= rx_meta_q;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sreg_q     <= sreg_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
            ovr_q      <= ovr_d;
            pend_q     <= pend_d;
        end
    end

    // rdy drops at every start detect, so overrun is tracked by pend_q: a byte
    // delivered and not yet acknowledged by clr_rdy.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sreg_d     = sreg_q;
        rx_data_d  = rx_data_q;
        rdy_d      = rdy_q;
        frm_err_d  = frm_err_q;
        ovr_d      = ovr_q;
        pend_d     = pend_q;
        shift      = 1'b0;

        if (bus.clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
            ovr_d     = 1'b0;
            pend_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d    = RECEIVE;
                    baud_cnt_d = HALF_DIV;
                    bit_cnt_d  = '0;
                    rdy_d      = 1'b0;
                end
            end
            RECEIVE: begin
                shift      = (baud_cnt_q == 12'd0);
                baud_cnt_d = baud_cnt_q - 12'd1;
                if (shift) begin
                    sreg_d     = {rx_s_q, sreg_q[8:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = BIT_DIV;
                    if (bit_cnt_q == 4'd0 && rx_s_q) begin
                        state_d = IDLE;
                    end else if (bit_cnt_q == 4'd9) begin
                        // sreg_q[0] holds the start sample, sreg_q[8:1] the data bits
                        rx_data_d = sreg_q[8:1];
                        rdy_d     = 1'b1;
                        frm_err_d = ~rx_s_q | sreg_q[0];
                        ovr_d     = ovr_q | pend_q;
                        pend_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;
    assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench: one receiver at the default bit period for the latency check,
// one at a short bit period for framing, overrun, reset and full byte sweep.
module tb_uart_rx;
    localparam int SLOW_DIV = 2604;
    localparam int FAST_DIV = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   lat;

    always #5 clk = ~clk;

    uart_rx_if slow_if ();
    uart_rx_if fast_if ();

    uart_rx #(.BAUD_DIV(SLOW_DIV)) slow_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (slow_if.slave)
    );

    uart_rx #(.BAUD_DIV(FAST_DIV)) fast_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fast_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic show(input string tag);
        $display("[%0t] %s rx_data=%02h rdy=%b frm_err=%b ovr=%b", $time, tag,
                 fast_if.rx_data, fast_if.rdy, fast_if.frm_err, fast_if.ovr);
    endtask

    // Called on a negedge; drives one frame, LSB first. A bad stop bit is held
    // low only past its mid-bit sample so it does not look like a new start.
    task automatic tx_frame(input logic [7:0] data, input logic stop);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            fast_if.RX = bits[i];
            if (i == 9 && !stop) begin
                repeat (7) @(negedge clk);
                fast_if.RX = 1'b1;
                repeat (FAST_DIV - 7) @(negedge clk);
            end else begin
                repeat (FAST_DIV) @(negedge clk);
            end
        end
        fast_if.RX = 1'b1;
    endtask

    task automatic clr_pulse();
        fast_if.clr_rdy = 1'b1;
        @(negedge clk);
        fast_if.clr_rdy = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_rdy"},     32'(fast_if.rdy),     32'd0);
        check({tag, "_frm_err"}, 32'(fast_if.frm_err), 32'd0);
        check({tag, "_ovr"},     32'(fast_if.ovr),     32'd0);
    endtask

    initial begin
        logic [9:0] slow_bits;
        slow_if.RX      = 1'b1;
        slow_if.clr_rdy = 1'b0;
        fast_if.RX      = 1'b1;
        fast_if.clr_rdy = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_rx_data", 32'(fast_if.rx_data), 32'h00);
        check_clear("rst");
        check("rst_slow_rdy", 32'(slow_if.rdy), 32'd0);
        show("reset");

        // Default bit period: 0xA5 and rdy latency from the falling edge
        slow_bits = {1'b1, 8'hA5, 1'b0};
        lat = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    slow_if.RX = slow_bits[i];
                    repeat (SLOW_DIV) @(negedge clk);
                end
                slow_if.RX = 1'b1;
            end
            begin
                while (slow_if.rdy !== 1'b1 && lat < 30000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        $display("[%0t] slow frame rx_data=%02h latency=%0d", $time, slow_if.rx_data, lat);
        check("slow_latency", 32'(lat >= 24737 && lat <= 24743), 32'd1);
        check("slow_rx_data", 32'(slow_if.rx_data), 32'hA5);
        check("slow_rdy", 32'(slow_if.rdy), 32'd1);
        check("slow_frm_err", 32'(slow_if.frm_err), 32'd0);
        check("slow_ovr", 32'(slow_if.ovr), 32'd0);

        // False start: short low pulse, no flags, then a clean frame
        fast_if.RX = 1'b0;
        repeat (3) @(negedge clk);
        fast_if.RX = 1'b1;
        repeat (20) @(negedge clk);
        show("false_start");
        check("fs_rx_data", 32'(fast_if.rx_data), 32'h00);
        check_clear("fs");
        tx_frame(8'h3C, 1'b1);
        show("frame_3C");
        check("f3c_rx_data", 32'(fast_if.rx_data), 32'h3C);
        check("f3c_rdy", 32'(fast_if.rdy), 32'd1);
        check("f3c_frm_err", 32'(fast_if.frm_err), 32'd0);
        clr_pulse();

        // Framing error and acknowledge
        tx_frame(8'h81, 1'b0);
        show("frame_81_bad_stop");
        check("f81_rx_data", 32'(fast_if.rx_data), 32'h81);
        check("f81_rdy", 32'(fast_if.rdy), 32'd1);
        check("f81_frm_err", 32'(fast_if.frm_err), 32'd1);
        check("f81_ovr", 32'(fast_if.ovr), 32'd0);
        clr_pulse();
        show("clr");
        check_clear("clr81");

        // Back-to-back frames, overrun, clr_rdy in the completion cycle
        tx_frame(8'h00, 1'b1);
        show("frame_00");
        check("f00_rx_data", 32'(fast_if.rx_data), 32'h00);
        check("f00_rdy", 32'(fast_if.rdy), 32'd1);
        check("f00_ovr", 32'(fast_if.ovr), 32'd0);
        fork
            tx_frame(8'hFF, 1'b1);
            begin
                repeat (98) @(negedge clk);
                fast_if.clr_rdy = 1'b1;
                @(negedge clk);
                fast_if.clr_rdy = 1'b0;
            end
        join
        show("frame_FF");
        check("fff_rx_data", 32'(fast_if.rx_data), 32'hFF);
        check("fff_rdy", 32'(fast_if.rdy), 32'd1);
        check("fff_ovr", 32'(fast_if.ovr), 32'd1);
        check("fff_frm_err", 32'(fast_if.frm_err), 32'd0);
        clr_pulse();
        check_clear("clrff");

        // Reset in the middle of data bit 4, then a clean frame
        fork
            tx_frame(8'h55, 1'b1);
            begin
                repeat (55) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                show("mid_frame_reset");
                check("mrst_rx_data", 32'(fast_if.rx_data), 32'h00);
                check_clear("mrst");
            end
        join
        repeat (80) @(negedge clk);
        clr_pulse();
        tx_frame(8'h55, 1'b1);
        show("frame_55");
        check("f55_rx_data", 32'(fast_if.rx_data), 32'h55);
        check("f55_rdy", 32'(fast_if.rdy), 32'd1);
        check("f55_frm_err", 32'(fast_if.frm_err), 32'd0);
        clr_pulse();

        // All byte values, back to back
        for (int v = 0; v < 256; v++) begin
            tx_frame(8'(v), 1'b1);
            $display("[%0t] sweep tx=%02h rx=%02h frm_err=%b", $time, 8'(v),
                     fast_if.rx_data, fast_if.frm_err);
            check("sweep_rx_data", 32'(fast_if.rx_data), 32'(v));
            check("sweep_frm_err", 32'(fast_if.frm_err), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
